// File: rtl/local_mem_st_queue.sv
`default_nettype none
// ============================================================================
// Module   : local_mem_st_queue
// Purpose  : In-order store queue feeding the local memory arbiter store port,
//            with a read-after-write hazard lookup over pending entries.
// Revision : 1.0 - initial release
// ============================================================================
module local_mem_st_queue #(
    parameter int DEPTH            = 4,
    parameter int LOCAL_MEM_ADDR_L = 16,
    parameter int DATA_L           = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [LOCAL_MEM_ADDR_L-1:0] in_addr,
    input  logic [DATA_L-1:0]           in_data,
    input  logic                        in_vld,
    output logic                        in_rdy,
    output logic [LOCAL_MEM_ADDR_L-1:0] st_local_mem_addr,
    output logic [DATA_L-1:0]           st_local_mem_data,
    output logic                        st_local_mem_st_req,
    input  logic                        st_local_mem_st_gnt,
    input  logic [LOCAL_MEM_ADDR_L-1:0] chk_addr,
    output logic                        chk_hit,
    output logic [$clog2(DEPTH):0]      occupancy,
    output logic                        empty,
    output logic                        full
);

    localparam int   c_PTR_W       = $clog2(DEPTH);
    localparam int   c_OCC_W       = c_PTR_W + 1;
    localparam logic c_RESET_STATE = 1'b0;

    logic [LOCAL_MEM_ADDR_L-1:0] r_addr [DEPTH];
    logic [DATA_L-1:0]           r_data [DEPTH];
    logic [DEPTH-1:0]            r_vld;
    logic [c_PTR_W-1:0]          r_wr_ptr;
    logic [c_PTR_W-1:0]          r_rd_ptr;
    logic [c_OCC_W-1:0]          r_occ;

    logic w_push;
    logic w_pop;
    logic w_hit;

    assign empty               = (r_occ == '0);
    assign full                = (r_occ == c_OCC_W'(DEPTH));
    assign in_rdy              = !full;
    assign occupancy           = r_occ;
    assign st_local_mem_st_req = !empty;
    assign st_local_mem_addr   = r_addr[r_rd_ptr];
    assign st_local_mem_data   = r_data[r_rd_ptr];

    assign w_push = in_vld && in_rdy;
    assign w_pop  = st_local_mem_st_req && st_local_mem_st_gnt;

    // Push and pop only share an index when empty or full, and neither case
    // allows both, so the valid-bit updates never collide.
    always_ff @(posedge clk or negedge rst) begin
        if (rst == c_RESET_STATE) begin
            r_vld    <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_occ    <= '0;
        end else begin
            if (w_pop) begin
                r_vld[r_rd_ptr] <= 1'b0;
                r_rd_ptr        <= r_rd_ptr + c_PTR_W'(1);
            end
            if (w_push) begin
                r_vld[r_wr_ptr] <= 1'b1;
                r_wr_ptr        <= r_wr_ptr + c_PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_occ <= r_occ + c_OCC_W'(1);
                2'b01:   r_occ <= r_occ - c_OCC_W'(1);
                default: r_occ <= r_occ;
            endcase
        end
    end

    // Payload storage carries no reset; the valid bits qualify it.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_addr[r_wr_ptr] <= in_addr;
            r_data[r_wr_ptr] <= in_data;
        end
    end

    always_comb begin
        w_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_vld[i] && (r_addr[i] == chk_addr)) begin
                w_hit = 1'b1;
            end
        end
    end

    assign chk_hit = w_hit;

    a_gnt_needs_req : assert property (@(posedge clk) disable iff (rst == c_RESET_STATE)
        st_local_mem_st_gnt |-> st_local_mem_st_req);

    a_in_held_stable : assert property (@(posedge clk) disable iff (rst == c_RESET_STATE)
        (in_vld && !in_rdy) |=> (in_vld && $stable(in_addr) && $stable(in_data)));

endmodule
`default_nettype wire
